fsm_read_responder: RTL and testbench



---
 rtl/fsm_read_responder.sv | 134 +++++++++++++
 tb/tb_fsm_read_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_read_responder.sv
// Target-side responder for the single-strobe rd/ws read handshake: inserts programmable
// wait-state pairs, then returns one word from a small register file via an auto-incrementing pointer.
// Optional even-parity output rpar is enabled by defining FSM_RESP_PARITY_EN.
module fsm_read_responder #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    output logic              ws,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              ptr_load,
    input  logic [AW-1:0]     base_addr,
    output logic [DW-1:0]     rdata,
    output logic              rvalid,
    output logic              busy,
`ifdef FSM_RESP_PARITY_EN
    output logic              rpar,
`endif
    output logic              proto_err
);

    // state  | meaning
    // IDLE   | waiting for rd
    // DLY_PH | aligned to initiator DLY cycle; ws driven here
    // RD_PH  | aligned to initiator repeated READ cycle
    // DATA   | rdata freshly captured, rvalid pulse
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DLY_PH = 2'd1,
        RD_PH  = 2'd2,
        DATA   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wcnt, wcnt_nxt;
    logic [AW-1:0]     ptr, ptr_nxt;
    logic              capture;
    logic              err_set;
    logic [DW-1:0]     mem [2**AW];
    logic [DW-1:0]     cap_data;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // A write landing on the word being captured is forwarded so the reader sees the new value.
    assign cap_data = (wr_en && (wr_addr == ptr)) ? wr_data : mem[ptr];

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        ptr_nxt   = ptr;
        capture   = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (rd) begin
                    state_nxt = DLY_PH;
                    wcnt_nxt  = wait_cfg;
                end
                if (ptr_load)
                    ptr_nxt = base_addr;
            end
            DLY_PH: begin
                if (!rd) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else if (wcnt != '0) begin
                    state_nxt = RD_PH;
                    wcnt_nxt  = wcnt - WAIT_W'(1);
                end else begin
                    state_nxt = DATA;
                    capture   = 1'b1;
                    ptr_nxt   = ptr + AW'(1);
                end
            end
            RD_PH: begin
                if (rd) begin
                    state_nxt = DLY_PH;
                end else begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                state_nxt = IDLE;
                if (rd)
                    err_set = 1'b1;
                if (ptr_load)
                    ptr_nxt = base_addr;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            ptr       <= '0;
            rdata     <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            ptr   <= ptr_nxt;
            if (capture)
                rdata <= cap_data;
            if (err_set)
                proto_err <= 1'b1;
        end
    end

`ifdef FSM_RESP_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            rpar <= 1'b0;
        else if (capture)
            rpar <= ^cap_data;
    end
`endif

    assign ws     = (state == DLY_PH) && (wcnt != '0);
    assign rvalid = (state == DATA);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_fsm_read_responder.sv
// Self-checking bench for fsm_read_responder: table-driven accesses with a read-data
// scoreboard, plus hand sequences for write-forward, protocol error and mid-access reset.
module tb_fsm_read_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd;
    logic       ws;
    logic [3:0] wait_cfg;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       ptr_load;
    logic [3:0] base_addr;
    logic [7:0] rdata;
    logic       rvalid;
    logic       busy;
    logic       proto_err;
`ifdef FSM_RESP_PARITY_EN
    logic       rpar;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] q [$];

    typedef struct {
        int         wcfg;
        logic       ld;
        logic [3:0] base;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    fsm_read_responder #(.DW(8), .AW(4), .WAIT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .ws        (ws),
        .wait_cfg  (wait_cfg),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ptr_load  (ptr_load),
        .base_addr (base_addr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy),
`ifdef FSM_RESP_PARITY_EN
        .rpar      (rpar),
`endif
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rvalid pulse must consume one expected word.
    always @(negedge clk) begin
        if (rvalid) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                chk("sb_rdata", 32'(rdata), 32'(e));
`ifdef FSM_RESP_PARITY_EN
                chk("sb_rpar", 32'(rpar), 32'(^e));
`endif
            end
        end
    end

    task automatic do_read(input int n, input logic fwd, input logic [3:0] fa,
                           input logic [7:0] fd, input logic [7:0] exp);
        int last;
        last = 2 * n + 1;
        q.push_back(exp);
        wait_cfg = 4'(n);
        for (int k = 0; k <= last; k++) begin
            rd = 1'b1;
            if (k == last && fwd) begin
                wr_en   = 1'b1;
                wr_addr = fa;
                wr_data = fd;
            end
            if (k % 2 == 1)
                chk("ws_dly", 32'(ws), 32'((n - (k - 1) / 2) != 0));
            else
                chk("ws_rd", 32'(ws), 32'd0);
            chk("busy_access", 32'(busy), 32'(k > 0));
            step();
            wr_en = 1'b0;
        end
        rd = 1'b0;
        chk("rvalid_pulse", 32'(rvalid), 32'd1);
        chk("busy_data", 32'(busy), 32'd1);
        chk("rdata_direct", 32'(rdata), 32'(exp));
        step();
        chk("rvalid_end", 32'(rvalid), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("rdata_hold", 32'(rdata), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{wcfg: 0,  ld: 1'b0, base: 4'h0, exp: 8'hA0};
        vecs[1] = '{wcfg: 3,  ld: 1'b0, base: 4'h0, exp: 8'hA1};
        vecs[2] = '{wcfg: 1,  ld: 1'b1, base: 4'hF, exp: 8'hAF};
        vecs[3] = '{wcfg: 0,  ld: 1'b0, base: 4'h0, exp: 8'hA0};
        vecs[4] = '{wcfg: 15, ld: 1'b1, base: 4'h7, exp: 8'hA7};
        vecs[5] = '{wcfg: 2,  ld: 1'b0, base: 4'h0, exp: 8'hA8};

        rst = 1'b1; rd = 1'b0; wait_cfg = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; ptr_load = 1'b0; base_addr = '0;
        step(); step();
        chk("rst_ws", 32'(ws), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
`ifdef FSM_RESP_PARITY_EN
        chk("rst_rpar", 32'(rpar), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'hA0 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        step();

        foreach (vecs[i]) begin
            if (vecs[i].ld) begin
                ptr_load = 1'b1; base_addr = vecs[i].base;
                step();
                ptr_load = 1'b0;
            end
            do_read(vecs[i].wcfg, 1'b0, 4'h0, 8'h00, vecs[i].exp);
            step();
        end

        // ptr is now 9: forwarded writes during the capture cycle
        do_read(1, 1'b1, 4'h9, 8'h5C, 8'h5C);
        step();
        do_read(0, 1'b1, 4'hA, 8'h01, 8'h01);
        step();

        // rd dropped in RD_PH: error, no data, pointer unchanged (still 11)
        wait_cfg = 4'd2;
        rd = 1'b1; step();
        chk("perr_ws_dly", 32'(ws), 32'd1);
        step();
        chk("perr_in_rd_ph", 32'(busy), 32'd1);
        rd = 1'b0; step();
        chk("perr_set", 32'(proto_err), 32'd1);
        chk("perr_no_rvalid", 32'(rvalid), 32'd0);
        chk("perr_idle", 32'(busy), 32'd0);
        step();
        do_read(0, 1'b0, 4'h0, 8'h00, 8'hAB);
        chk("perr_sticky", 32'(proto_err), 32'd1);
        step();

        // reset while DLY_PH with ws asserted
        wait_cfg = 4'd3;
        rd = 1'b1; step();
        chk("mid_ws_high", 32'(ws), 32'd1);
        rst = 1'b1; step();
        rst = 1'b0; rd = 1'b0;
        chk("mid_rst_ws", 32'(ws), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_perr", 32'(proto_err), 32'd0);
        step();
        do_read(0, 1'b0, 4'h0, 8'h00, 8'hA0);
        step(); step();

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
